// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x DATA_W MIPS register file with write-back bypass
// plus a per-register pending-write scoreboard that generates the ID stall.
//
// Issue handshake: an instruction presented with issue_valid=1 is taken on the
// rising edge where stall=0. While stall=1 nothing is recorded for it and the
// producer must present it again on a later cycle. Write-back (wr_en) is never
// back-pressured.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   input  logic              rs_used,
   input  logic              rt_used,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_valid,
   input  logic              issue_wen,
   input  logic [4:0]        issue_dst,
   output logic              stall,
   output logic [31:0]       busy_mask,
   output logic              err_uflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs [32];
   logic [CNT_W-1:0]  cnt  [32];
   logic              err_q;

   logic        retire;
   logic        accept;
   logic        rs_ready;
   logic        rt_ready;
   logic        dst_full;
   logic [31:0] inc_vec;
   logic [31:0] dec_vec;

   assign err_uflow = err_q;

   // Hazard detection: a source is ready when nothing is pending on it, or
   // its last producer is writing back this very cycle (bypass covers it).
   always_comb begin
      retire   = wr_en && (wr_addr != 5'd0);
      rs_ready = (rs_addr == 5'd0) || (cnt[rs_addr] == '0) ||
                 (retire && (wr_addr == rs_addr) && (cnt[rs_addr] == CNT_ONE));
      rt_ready = (rt_addr == 5'd0) || (cnt[rt_addr] == '0) ||
                 (retire && (wr_addr == rt_addr) && (cnt[rt_addr] == CNT_ONE));
      dst_full = issue_wen && (issue_dst != 5'd0) && (cnt[issue_dst] == CNT_MAX) &&
                 !(retire && (wr_addr == issue_dst));
      stall    = issue_valid && ((rs_used && !rs_ready) || (rt_used && !rt_ready) || dst_full);
      accept   = issue_valid && issue_wen && (issue_dst != 5'd0) && !stall;
      inc_vec  = accept ? (32'd1 << issue_dst) : 32'd0;
      dec_vec  = retire ? (32'd1 << wr_addr) : 32'd0;
   end

   // Read ports: register 0 is hard zero, same-cycle write-back is forwarded.
   always_comb begin
      if (rs_addr == 5'd0)
         rd1_data = '0;
      else if (retire && (wr_addr == rs_addr))
         rd1_data = wr_data;
      else
         rd1_data = regs[rs_addr];

      if (rt_addr == 5'd0)
         rd2_data = '0;
      else if (retire && (wr_addr == rt_addr))
         rd2_data = wr_data;
      else
         rd2_data = regs[rt_addr];
   end

   // Busy mask reflects registered counters only; register 0 never pends.
   always_comb begin
      for (int i = 0; i < 32; i++)
         busy_mask[i] = (cnt[i] != '0);
      busy_mask[0] = 1'b0;
   end

   // Register write, pending-counter update and sticky underflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
            cnt[i]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         if (retire)
            regs[wr_addr] <= wr_data;
         for (int r = 1; r < 32; r++) begin
            case ({inc_vec[r], dec_vec[r]})
               2'b10: cnt[r] <= cnt[r] + CNT_ONE;
               2'b01: begin
                  if (cnt[r] == '0)
                     err_q <= 1'b1;
                  else
                     cnt[r] <= cnt[r] - CNT_ONE;
               end
               default: cnt[r] <= cnt[r];
            endcase
         end
      end
   end

endmodule
